// File: rtl/processador_pio_saida_pkg.sv
// Shared constants and types for the pulse-capable output PIO.
// Register addresses, the pulse FSM state type and the readback bit positions.
package processador_pio_saida_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_t;

  localparam int STATUS_DONE_BIT = 0;
  localparam int PULSE_BUSY_BIT  = 31;

endpackage

// File: rtl/processador_pio_pulse_timer.sv
// Pulse engine: holds the inversion mask for max(len,1) cycles, then drops it.
// A start with a zero mask aborts; any start takes priority over expiry.
module processador_pio_pulse_timer
  import processador_pio_saida_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [CNT_W-1:0] i_len,
  output logic [WIDTH-1:0] o_active_mask,
  output logic             o_busy,
  output logic             o_done
);

  pulse_state_t     r_state;
  pulse_state_t     w_state_next;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_counter_next;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_mask_next;
  logic             w_done;
  logic [CNT_W-1:0] w_load_len;

  // A programmed length of zero still yields a one-cycle pulse.
  assign w_load_len = (i_len == '0) ? CNT_W'(1) : i_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
      r_mask    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_counter <= w_counter_next;
      r_mask    <= w_mask_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_counter_next = r_counter;
    w_mask_next    = r_mask;
    w_done         = 1'b0;
    if (i_start) begin
      if (i_mask != '0) begin
        w_state_next   = ST_PULSE;
        w_counter_next = w_load_len;
        w_mask_next    = i_mask;
      end else begin
        w_state_next   = ST_IDLE;
        w_counter_next = '0;
        w_mask_next    = '0;
      end
    end else if (r_state == ST_PULSE) begin
      if (r_counter == CNT_W'(1)) begin
        w_state_next   = ST_IDLE;
        w_counter_next = '0;
        w_mask_next    = '0;
        w_done         = 1'b1;
      end else begin
        w_counter_next = r_counter - CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_active_mask = r_mask;
    o_busy        = (r_state == ST_PULSE);
    o_done        = w_done;
  end

endmodule

// File: rtl/processador_pio_saida_pulso.sv
// Avalon-MM output PIO with set/clear writes and a timed inversion pulse.
// Optional sticky done flag and irq when PIO_SAIDA_PULSE_IRQ_EN is defined.
module processador_pio_saida_pulso
  import processador_pio_saida_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef PIO_SAIDA_PULSE_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_pulse_len;
  logic [31:0]      r_readdata;
  logic [31:0]      w_rd_next;
  logic             w_wr;
  logic             w_wr_data;
  logic             w_wr_status;
  logic             w_wr_len;
  logic             w_wr_pulse;
  logic             w_wr_set;
  logic             w_wr_clr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_active_mask;
  logic             w_busy;
  logic             w_pulse_done;
  logic             w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_data   = w_wr && (address == ADDR_DATA);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_wr_len    = w_wr && (address == ADDR_PULSE_LEN);
  assign w_wr_pulse  = w_wr && (address == ADDR_PULSE);
  assign w_wr_set    = w_wr && (address == ADDR_OUTSET);
  assign w_wr_clr    = w_wr && (address == ADDR_OUTCLEAR);
  assign w_wd        = writedata[WIDTH-1:0];

  processador_pio_pulse_timer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_pulse_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (w_wr_pulse),
    .i_mask       (w_wd),
    .i_len        (r_pulse_len),
    .o_active_mask(w_active_mask),
    .o_busy       (w_busy),
    .o_done       (w_pulse_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_wr_data) begin
      r_data <= w_wd;
    end else if (w_wr_set) begin
      r_data <= r_data | w_wd;
    end else if (w_wr_clr) begin
      r_data <= r_data & ~w_wd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse_len <= CNT_W'(1);
    end else if (w_wr_len) begin
      r_pulse_len <= writedata[CNT_W-1:0];
    end
  end

`ifdef PIO_SAIDA_PULSE_IRQ_EN
  logic r_done_flag;

  // A completion landing on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_flag <= 1'b0;
    end else if (w_pulse_done) begin
      r_done_flag <= 1'b1;
    end else if (w_wr_status) begin
      r_done_flag <= 1'b0;
    end
  end

  assign irq      = r_done_flag;
  assign w_unused = ^writedata;
`else
  assign w_unused = ^{writedata, w_pulse_done, w_wr_status};
`endif

  always_comb begin
    w_rd_next = '0;
    case (address)
      ADDR_DATA: w_rd_next[WIDTH-1:0] = r_data;
      ADDR_STATUS: begin
`ifdef PIO_SAIDA_PULSE_IRQ_EN
        w_rd_next[STATUS_DONE_BIT] = r_done_flag;
`endif
      end
      ADDR_PULSE_LEN: w_rd_next[CNT_W-1:0] = r_pulse_len;
      ADDR_PULSE: begin
        w_rd_next[PULSE_BUSY_BIT] = w_busy;
        w_rd_next[WIDTH-1:0]      = w_active_mask;
      end
      default: w_rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_next;
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_data ^ w_active_mask;

endmodule
